// File: rtl/arctan_arbiter_pkg.sv
// Shared SCARA math package: Arctan2 operand/result widths and the
// arbiter state encoding used by arctan_arbiter.
package arctan_arbiter_pkg;

   localparam int ARG_W_DEF   = 64;
   localparam int ANGLE_W_DEF = 13;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LAUNCH  = 2'd1,
      ST_BUSY    = 2'd2,
      ST_DELIVER = 2'd3
   } arb_state_e;

endpackage

// File: rtl/arctan_arbiter_rr_select.sv
// Round-robin winner selection for arctan_arbiter: the search starts at
// rr_ptr and the first set request bit wins. Purely combinational.
module arctan_arbiter_rr_select #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   win_idx,
   output logic               any_req
);

   int j;

   // scan requesters in rotated order, keep the first one found
   always_comb begin
      winner  = '0;
      win_idx = '0;
      any_req = 1'b0;
      j       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any_req && req[j]) begin
            any_req    = 1'b1;
            winner[j]  = 1'b1;
            win_idx    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/arctan_arbiter.sv
// arctan_arbiter: shares one Arctan2 unit among NUM_REQ requesters.
// Optional watchdog enabled by defining ARCTAN_ARB_TIMEOUT_EN; the default
// build has no counter and ties timeout low.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | unit held in reset, no grant, arbitrating pending requests
//   ST_LAUNCH  | one cycle: grant + operands driven, enable raised
//   ST_BUSY    | waiting for atan_ready, watching for abandon / watchdog
//   ST_DELIVER | one cycle: done pulse, result in angle, unit back in reset
module arctan_arbiter
   import arctan_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 3,
   parameter int ARG_W          = ARG_W_DEF,
   parameter int ANGLE_W        = ANGLE_W_DEF,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*ARG_W-1:0]   arg1,
   input  logic [NUM_REQ*ARG_W-1:0]   arg2,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         done,
   output logic signed [ANGLE_W-1:0]  angle,
   output logic [ARG_W-1:0]           atan_arg1,
   output logic [ARG_W-1:0]           atan_arg2,
   output logic                       atan_enable,
   output logic                       atan_reset,
   input  logic signed [ANGLE_W-1:0]  atan_angle,
   input  logic                       atan_ready,
   output logic                       timeout
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   arb_state_e                state_q, state_d;
   logic [NUM_REQ-1:0]        grant_q, grant_d;
   logic [NUM_REQ-1:0]        done_q, done_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic signed [ANGLE_W-1:0] angle_q, angle_d;
   logic [ARG_W-1:0]          a1_q, a1_d, a2_q, a2_d;
   logic                      en_q, en_d, arst_q, arst_d;

   logic [NUM_REQ-1:0]        sel_onehot;
   logic [IDX_W-1:0]          sel_idx;
   logic                      sel_any;
   logic [ARG_W-1:0]          sel_a1, sel_a2;
   logic [IDX_W-1:0]          next_ptr;
   logic                      abandon;
   logic                      to_hit;
   logic                      go_idle;

   arctan_arbiter_rr_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) rr_select (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .winner  (sel_onehot),
      .win_idx (sel_idx),
      .any_req (sel_any)
   );

   // the owner dropping its request while in flight abandons the operation
   assign abandon  = ~|(req & grant_q);
   assign next_ptr = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

   // operand mux from the selected requester
   always_comb begin
      sel_a1 = '0;
      sel_a2 = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (sel_onehot[k]) begin
            sel_a1 = arg1[k*ARG_W +: ARG_W];
            sel_a2 = arg2[k*ARG_W +: ARG_W];
         end
      end
   end

`ifdef ARCTAN_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic             timeout_q, timeout_d;

   // watchdog counts BUSY cycles; fires on the TIMEOUT_CYCLES-th one
   always_comb begin
      wd_cnt_d  = (state_q == ST_BUSY) ? wd_cnt_q + CNT_W'(1) : '0;
      timeout_d = (state_q == ST_BUSY) && !abandon && to_hit;
   end

   assign to_hit  = (wd_cnt_q == CNT_LAST);
   assign timeout = timeout_q;
`else
   assign to_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   // next-state and registered-output computation
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      done_d   = '0;
      idx_d    = idx_q;
      rr_ptr_d = rr_ptr_q;
      angle_d  = angle_q;
      a1_d     = a1_q;
      a2_d     = a2_q;
      en_d     = en_q;
      arst_d   = arst_q;
      go_idle  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_any) begin
               state_d = ST_LAUNCH;
               grant_d = sel_onehot;
               idx_d   = sel_idx;
               a1_d    = sel_a1;
               a2_d    = sel_a2;
               en_d    = 1'b1;
               arst_d  = 1'b0;
            end
         end
         ST_LAUNCH: begin
            if (abandon) go_idle = 1'b1;
            else         state_d = ST_BUSY;
         end
         ST_BUSY: begin
            // abandon outranks a coincident ready
            if (abandon || to_hit) begin
               go_idle = 1'b1;
            end else if (atan_ready) begin
               state_d = ST_DELIVER;
               angle_d = atan_angle;
               done_d  = grant_q;
               en_d    = 1'b0;
               arst_d  = 1'b1;
            end
         end
         ST_DELIVER: go_idle = 1'b1;
         default:    go_idle = 1'b1;
      endcase
      if (go_idle) begin
         state_d  = ST_IDLE;
         grant_d  = '0;
         a1_d     = '0;
         a2_d     = '0;
         en_d     = 1'b0;
         arst_d   = 1'b1;
         rr_ptr_d = next_ptr;
      end
   end

   // state and output registers, cleared immediately on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         done_q    <= '0;
         idx_q     <= '0;
         rr_ptr_q  <= '0;
         angle_q   <= '0;
         a1_q      <= '0;
         a2_q      <= '0;
         en_q      <= 1'b0;
         arst_q    <= 1'b1;
`ifdef ARCTAN_ARB_TIMEOUT_EN
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         idx_q     <= idx_d;
         rr_ptr_q  <= rr_ptr_d;
         angle_q   <= angle_d;
         a1_q      <= a1_d;
         a2_q      <= a2_d;
         en_q      <= en_d;
         arst_q    <= arst_d;
`ifdef ARCTAN_ARB_TIMEOUT_EN
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign grant       = grant_q;
   assign done        = done_q;
   assign angle       = angle_q;
   assign atan_arg1   = a1_q;
   assign atan_arg2   = a2_q;
   assign atan_enable = en_q;
   assign atan_reset  = arst_q;

endmodule
